stage_menu_nav: RTL

//  Parametrised N-option menu stage: cursor navigation with up/down keys, optional wrap and hold-to-repeat.

---
 rtl/stage_pkg.sv | 21 ++
 rtl/stage_menu_nav_key_repeat.sv | 49 ++++
 rtl/stage_menu_nav.sv | 127 ++++++++++++
 3 files changed

// File: rtl/stage_pkg.sv
// Shared stage identifiers, screen geometry and the menu FSM state type.
package stage_pkg;

    localparam logic [3:0] STAGE_MENU  = 4'd0;
    localparam logic [3:0] STAGE_START = 4'd1;
    localparam logic [3:0] STAGE_LOAD  = 4'd2;
    localparam logic [3:0] STAGE_DEATH = 4'd3;
    localparam logic [3:0] STAGE_FINAL = 4'd4;
    localparam logic [3:0] STAGE_EXIT  = 4'd5;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int ADDR_W   = 25;

    typedef enum logic [1:0] {
        BROWSE  = 2'd0,
        CONFIRM = 2'd1,
        RELEASE = 2'd2
    } menu_state_t;

endpackage

// File: rtl/stage_menu_nav_key_repeat.sv
// Key step generator: one pulse on a rising edge, then one pulse every
// REPEAT_FRAMES frames while the key stays held. A disabled block forgets
// the key history so nothing is acted on while the stage is inactive.
module key_repeat #(
    parameter int REPEAT_FRAMES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic level,
    output logic step
);
    import stage_pkg::*;

    localparam int CNT_W = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;

    logic             prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Edge detect plus hold counter; the counter restarts on every press.
    always_comb begin
        prev_d = en & level;
        cnt_d  = '0;
        step   = 1'b0;
        if (en && level) begin
            if (!prev_q) begin
                step = 1'b1;
            end else if (REPEAT_FRAMES != 0) begin
                if (cnt_q == CNT_W'(REPEAT_FRAMES - 1)) begin
                    step = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    // Key history and hold counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/stage_menu_nav.sv
// Menu stage: up/down cursor navigation, enter/ack confirm handshake and the
// per-option framebuffer address (zero when this stage is not active so it
// can be OR-combined with the other stages' addresses).
module stage_menu_nav #(
    parameter int         NUM_OPTIONS   = 3,
    parameter logic [3:0] STAGE_ID      = stage_pkg::STAGE_MENU,
    parameter logic [3:0] SEL_OFFSET    = 4'd1,
    parameter int         ADDR_W        = stage_pkg::ADDR_W,
    parameter int         SCREEN_W      = stage_pkg::SCREEN_W,
    parameter int         BASE_ADDR     = 243648,
    parameter int         OPTION_STRIDE = 307200,
    parameter int         WRAP          = 1,
    parameter int         REPEAT_FRAMES = 8,
    localparam int        CW            = $clog2(NUM_OPTIONS)
) (
    input  logic              frame_clk,
    input  logic              Reset_n,
    input  logic [3:0]        stage,
    input  logic [9:0]        DrawX_write,
    input  logic [9:0]        DrawY_write,
    input  logic              up,
    input  logic              down,
    input  logic              enter,
    input  logic              confirm_ack,
    output logic [ADDR_W-1:0] Address,
    output logic [CW-1:0]     cursor,
    output logic [3:0]        selected_stage,
    output logic              confirmed
);
    import stage_pkg::*;

    localparam logic [CW-1:0] LAST = CW'(NUM_OPTIONS - 1);

    logic          active;
    logic          up_step, down_step;
    logic          enter_prev_q, enter_prev_d, enter_edge;
    menu_state_t   state_q, state_d;
    logic [CW-1:0] cursor_q, cursor_d, cursor_inc, cursor_dec;
    logic [3:0]    sel_q, sel_d, cur_sel;
    logic [31:0]   addr_sum;

    assign active = (stage == STAGE_ID);

    key_repeat #(.REPEAT_FRAMES(REPEAT_FRAMES)) u_up (
        .clk   (frame_clk),
        .rst_n (Reset_n),
        .en    (active),
        .level (up),
        .step  (up_step)
    );

    key_repeat #(.REPEAT_FRAMES(REPEAT_FRAMES)) u_down (
        .clk   (frame_clk),
        .rst_n (Reset_n),
        .en    (active),
        .level (down),
        .step  (down_step)
    );

    assign enter_prev_d = active & enter;
    assign enter_edge   = active & enter & ~enter_prev_q;
    assign cur_sel      = 4'(cursor_q) + SEL_OFFSET;

    // Neighbour positions; the ends either wrap or saturate.
    always_comb begin
        cursor_inc = cursor_q + 1'b1;
        cursor_dec = cursor_q - 1'b1;
        if (cursor_q == LAST) begin
            cursor_inc = (WRAP != 0) ? '0 : cursor_q;
        end
        if (cursor_q == '0) begin
            cursor_dec = (WRAP != 0) ? LAST : cursor_q;
        end
    end

    // Next-state logic: browse moves, enter latches, ack/stage-exit release.
    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        sel_d    = sel_q;
        case (state_q)
            BROWSE: begin
                if (enter_edge) begin
                    sel_d   = cur_sel;
                    state_d = CONFIRM;
                end else if (active && (up_step ^ down_step)) begin
                    cursor_d = down_step ? cursor_inc : cursor_dec;
                end
            end
            CONFIRM: begin
                if (!active || confirm_ack) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!enter) begin
                    state_d = BROWSE;
                end
            end
            default: state_d = BROWSE;
        endcase
    end

    // FSM, cursor, latched selection and enter history registers.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= BROWSE;
            cursor_q     <= '0;
            sel_q        <= SEL_OFFSET;
            enter_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cursor_q     <= cursor_d;
            sel_q        <= sel_d;
            enter_prev_q <= enter_prev_d;
        end
    end

    assign addr_sum = 32'(DrawX_write) + 32'(DrawY_write) * 32'(SCREEN_W)
                    + 32'(BASE_ADDR) + 32'(cursor_q) * 32'(OPTION_STRIDE);

    assign Address        = active ? ADDR_W'(addr_sum) : '0;
    assign cursor         = cursor_q;
    assign confirmed      = (state_q == CONFIRM);
    assign selected_stage = (state_q == BROWSE) ? cur_sel : sel_q;

endmodule
